// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: bus-snooping transmit FIFO feeding an 8N1 UART serialiser
module uart_tx_mmio #(
  parameter logic [7:0] TX_ADDR = 8'hFF,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic wr_en,
  output logic tx,
  output logic busy,
  output logic fifo_empty,
  output logic fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic hit, push, pop, baud_end;
  logic [CW-1:0] count_nxt;
  always_comb begin
    hit = wr_en && addr_in == TX_ADDR;
    push = hit && !fifo_full;
    baud_end = baud_cnt == BW'(CLKS_PER_BIT - 1);
    pop = !fifo_empty && (state == IDLE || (state == STOP && baud_end));
    count_nxt = fifo_count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifo_count <= count_nxt;
      fifo_empty <= count_nxt == '0;
      fifo_full <= count_nxt == CW'(FIFO_DEPTH);
      overflow <= overflow | (hit && fifo_full);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      baud_cnt <= '0;
    end else begin
      baud_cnt <= (state == IDLE || baud_end) ? '0 : baud_cnt + BW'(1);
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= START;
            tx <= 1'b0;
            busy <= 1'b1;
          end
        end
        START: if (baud_end) begin
          state <= DATA;
          tx <= shreg[0];
        end
        DATA: if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            state <= STOP;
            tx <= 1'b1;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg <= shreg >> 1;
            tx <= shreg[1];
          end
        end
        STOP: if (baud_end) begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= START;
            tx <= 1'b0;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: vector table plus frame-decoding scoreboard for uart_tx_mmio
module tb_uart_tx_mmio;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [7:0] addr_in = '0;
  logic [7:0] data_in = '0;
  logic tx, busy, fifo_empty, fifo_full, overflow;
  logic [2:0] fifo_count;
  uart_tx_mmio #(.TX_ADDR(8'hFF), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
    .tx(tx), .busy(busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic we;
    logic [7:0] a;
    logic [7:0] d;
    int cnt;
    logic ovf;
    logic acc;
    logic idle;
  } vec_t;
  int vecs = 0;
  int errs = 0;
  logic [7:0] byte_q[$];
  int mon_ph = -1;
  logic [7:0] mon_byte;
  int frames_seen = 0;
  int busy_cycles = 0;
  int busy_rises = 0;
  logic busy_q = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [7:0] a, input logic [7:0] d, input logic acc);
    wr_en = we;
    addr_in = a;
    data_in = d;
    if (acc) byte_q.push_back(d);
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (busy && !busy_q) busy_rises++;
    busy_q = busy;
  end
  always @(negedge clk) begin
    if (mon_ph >= 0 && !busy) mon_ph = -1;
    else if (mon_ph < 0) begin
      if (tx === 1'b0) begin
        mon_ph = 0;
        mon_byte = '0;
      end
    end else begin
      mon_ph++;
      if (mon_ph % CPB == CPB / 2) begin
        int j;
        j = mon_ph / CPB;
        if (j == 0) check("start_bit", {31'd0, tx}, 32'd0);
        else if (j <= 8) mon_byte[j-1] = tx;
        else begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          frames_seen++;
          if (byte_q.size() == 0) check("frame_unexpected", {24'd0, mon_byte}, 32'hFFFF_FFFF);
          else check("frame_byte", {24'd0, mon_byte}, {24'd0, byte_q.pop_front()});
          mon_ph = -1;
        end
      end
    end
  end
  initial begin
    vec_t tbl[8];
    logic [9:0] frame;
    int b0, r0, f0, lows;
    tbl[0] = '{1'b1, 8'hFE, 8'h3C, 0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'hFF, 8'h3C, 0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'hFF, 8'h01, 1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'h02, 1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'hFF, 8'h03, 2, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'hFF, 8'h04, 3, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'hFF, 8'h05, 4, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'hFF, 8'h06, 4, 1'b1, 1'b0, 1'b0};
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    drive(1'b1, 8'hFF, 8'hA5, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 10 * CPB; i++) begin
      check("a5_tx", {31'd0, tx}, {31'd0, frame[i/CPB]});
      check("a5_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("a5_end_busy", {31'd0, busy}, 32'd0);
    check("a5_end_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    b0 = busy_cycles;
    r0 = busy_rises;
    f0 = frames_seen;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].acc);
      @(negedge clk);
      check("vec_count", {29'd0, fifo_count}, tbl[i].cnt);
      check("vec_ovf", {31'd0, overflow}, {31'd0, tbl[i].ovf});
      check("vec_empty", {31'd0, fifo_empty}, {31'd0, tbl[i].cnt == 0});
      check("vec_full", {31'd0, fifo_full}, {31'd0, tbl[i].cnt == 4});
      if (tbl[i].idle) begin
        check("vec_idle_tx", {31'd0, tx}, 32'd1);
        check("vec_idle_busy", {31'd0, busy}, 32'd0);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    wait_idle("burst_timeout");
    check("burst_busy_cycles", busy_cycles - b0, 50 * CPB);
    check("burst_busy_rises", busy_rises - r0, 1);
    check("burst_frames", frames_seen - f0, 5);
    check("burst_drained", byte_q.size(), 0);
    check("burst_ovf_sticky", {31'd0, overflow}, 32'd1);
    f0 = frames_seen;
    drive(1'b1, 8'hFF, 8'h11, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'h22, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'h33, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("abort_pre_count", {29'd0, fifo_count}, 32'd2);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    byte_q.delete();
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_count", {29'd0, fifo_count}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    check("abort_empty", {31'd0, fifo_empty}, 32'd1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("abort_quiet", lows, 0);
    check("abort_frames", frames_seen - f0, 0);
    f0 = frames_seen;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hFF, 8'h40 + 8'(i), 1'b1);
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (36) @(negedge clk);
    check("popw_pre_count", {29'd0, fifo_count}, 32'd4);
    check("popw_pre_full", {31'd0, fifo_full}, 32'd1);
    check("popw_pre_ovf", {31'd0, overflow}, 32'd0);
    drive(1'b1, 8'hFF, 8'h77, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("popw_count", {29'd0, fifo_count}, 32'd3);
    check("popw_ovf", {31'd0, overflow}, 32'd1);
    check("popw_full", {31'd0, fifo_full}, 32'd0);
    wait_idle("popw_timeout");
    check("popw_frames", frames_seen - f0, 5);
    check("popw_drained", byte_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end
endmodule
